led_select_scheduler: RTL and testbench

Sequencer that drives the select lines of the 1-to-4 LED demux and the enable of the toggle counter. It replaces direct switch-to-select wiring on the demux/count top level. It supports three modes: manual stepping, automatic scan, and bounce scan. Automatic modes advance the LED position after a programmable number of toggle-counter edges. Switch 1 cycles the mode; switch 2 steps the select in manual mode and pauses/resumes in automatic modes.

---
 rtl/led_select_scheduler_if.sv | 18 +
 rtl/led_select_scheduler.sv | 99 +++++++++
 tb/tb_led_select_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_select_scheduler_if.sv
// led_select_scheduler_if: switch/toggle inputs and LED select/status outputs of the scheduler.
//   i_Switch_1, i_Switch_2 : debounced switch levels (mode advance / step-or-pause)
//   i_Toggle               : level output of the toggle counter
//   o_Enable               : toggle counter enable, low only while paused
//   o_Sel[1:0]             : demux select
//   o_Mode[1:0]            : 0 MANUAL, 1 SCAN, 2 BOUNCE
//   o_Paused               : automatic mode paused
interface led_select_scheduler_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Toggle;
    logic       o_Enable;
    logic [1:0] o_Sel;
    logic [1:0] o_Mode;
    logic       o_Paused;
    modport master (output i_Switch_1, i_Switch_2, i_Toggle, input o_Enable, o_Sel, o_Mode, o_Paused);
    modport slave (input i_Switch_1, i_Switch_2, i_Toggle, output o_Enable, o_Sel, o_Mode, o_Paused);
endinterface

// File: rtl/led_select_scheduler.sv
// led_select_scheduler: sequences the LED demux select (manual step, scan, bounce) and gates the toggle counter.
//   i_Clk   : system clock, rising edge
//   i_Reset : synchronous active-high reset
//   bus     : led_select_scheduler_if.slave (switch/toggle inputs, select/mode/pause/enable outputs)
//   DWELL_EDGES : toggle edges per LED position in automatic modes (1..255)
//   Define LED_SCHED_BOUNCE_EN to include BOUNCE mode; without it the mode cycle is MANUAL -> SCAN.
module led_select_scheduler #(
    parameter int DWELL_EDGES = 4
) (
    input logic                   i_Clk,
    input logic                   i_Reset,
    led_select_scheduler_if.slave bus
);
    typedef enum logic [1:0] {MANUAL = 2'd0, SCAN = 2'd1, BOUNCE = 2'd2} mode_t;
    mode_t      mode_q, mode_d;
    logic [1:0] sel_q, sel_d, sel_adv;
    logic [7:0] dwell_q, dwell_d;
    logic       paused_q, paused_d;
    logic       sw1_q, sw1_d, sw2_q, sw2_d, tog_q, tog_d;
    logic       sw1_rise, sw2_rise, tog_edge, at_end;
`ifdef LED_SCHED_BOUNCE_EN
    logic       up_q, up_d, step_up;
`endif

    // Previous-value registers load the live inputs during reset too, so a level held through reset is not an edge.
    always_ff @(posedge i_Clk) begin
        sw1_q <= sw1_d;
        sw2_q <= sw2_d;
        tog_q <= tog_d;
        if (i_Reset) begin
            mode_q   <= MANUAL;
            sel_q    <= 2'd0;
            dwell_q  <= 8'd0;
            paused_q <= 1'b0;
`ifdef LED_SCHED_BOUNCE_EN
            up_q     <= 1'b1;
`endif
        end else begin
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
            paused_q <= paused_d;
`ifdef LED_SCHED_BOUNCE_EN
            up_q     <= up_d;
`endif
        end
    end

    always_comb begin
        sw1_d    = bus.i_Switch_1;
        sw2_d    = bus.i_Switch_2;
        tog_d    = bus.i_Toggle;
        sw1_rise = bus.i_Switch_1 & ~sw1_q;
        sw2_rise = bus.i_Switch_2 & ~sw2_q;
        tog_edge = bus.i_Toggle ^ tog_q;
        at_end   = dwell_q == 8'(DWELL_EDGES - 1);
        mode_d   = mode_q;
        sel_d    = sel_q;
        dwell_d  = dwell_q;
        paused_d = paused_q;
`ifdef LED_SCHED_BOUNCE_EN
        up_d     = up_q;
        // Turn around at the ends on the same advance, so the end position is never repeated.
        step_up  = up_q ? (sel_q != 2'd3) : (sel_q == 2'd0);
        sel_adv  = (mode_q == BOUNCE && !step_up) ? sel_q - 2'd1 : sel_q + 2'd1;
`else
        sel_adv  = sel_q + 2'd1;
`endif
        // Priority: mode change, then manual step / pause toggle, then dwell counting.
        if (sw1_rise) begin
`ifdef LED_SCHED_BOUNCE_EN
            mode_d = mode_q == MANUAL ? SCAN : (mode_q == SCAN ? BOUNCE : MANUAL);
            up_d   = 1'b1;
`else
            mode_d = mode_q == MANUAL ? SCAN : MANUAL;
`endif
            dwell_d  = 8'd0;
            paused_d = 1'b0;
        end else if (mode_q == MANUAL) begin
            dwell_d = 8'd0;
            sel_d   = sw2_rise ? sel_q + 2'd1 : sel_q;
        end else if (sw2_rise) begin
            paused_d = ~paused_q;
        end else if (tog_edge && !paused_q) begin
            dwell_d = at_end ? 8'd0 : dwell_q + 8'd1;
            sel_d   = at_end ? sel_adv : sel_q;
`ifdef LED_SCHED_BOUNCE_EN
            up_d    = (at_end && mode_q == BOUNCE) ? step_up : up_q;
`endif
        end
    end

    always_comb begin
        bus.o_Sel    = sel_q;
        bus.o_Mode   = mode_q;
        bus.o_Paused = paused_q;
        bus.o_Enable = ~paused_q;
    end
endmodule

// File: tb/tb_led_select_scheduler.sv
// tb_led_select_scheduler: vector-table bench for led_select_scheduler (DWELL_EDGES 4 and 1 instances).
module tb_led_select_scheduler;
    typedef struct {
        logic       rst, s1, s2, tg, use1;
        logic [1:0] sel, mode;
        logic       pau;
    } vec_t;

`ifdef LED_SCHED_BOUNCE_EN
    localparam logic [1:0] M2 = 2'd2;
`else
    localparam logic [1:0] M2 = 2'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    led_select_scheduler_if b4();
    led_select_scheduler_if b1();
    led_select_scheduler #(.DWELL_EDGES(4)) u4 (.i_Clk(clk), .i_Reset(rst), .bus(b4.slave));
    led_select_scheduler #(.DWELL_EDGES(1)) u1 (.i_Clk(clk), .i_Reset(rst), .bus(b1.slave));

    function automatic void add(input logic r, a, b, t, input logic [1:0] sel, mode, input logic p, input logic u = 1'b0);
        vec_t v;
        v.rst = r; v.s1 = a; v.s2 = b; v.tg = t; v.sel = sel; v.mode = mode; v.pau = p; v.use1 = u;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        b4.i_Switch_1 = v.s1; b4.i_Switch_2 = v.s2; b4.i_Toggle = v.tg;
        b1.i_Switch_1 = v.s1; b1.i_Switch_2 = v.s2; b1.i_Toggle = v.tg;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.use1) begin
            chk("sel1", idx, b1.o_Sel, e.sel);
            chk("mode1", idx, b1.o_Mode, e.mode);
            chk("paused1", idx, {1'b0, b1.o_Paused}, {1'b0, e.pau});
            chk("enable1", idx, {1'b0, b1.o_Enable}, {1'b0, ~e.pau});
        end else begin
            chk("sel", idx, b4.o_Sel, e.sel);
            chk("mode", idx, b4.o_Mode, e.mode);
            chk("paused", idx, {1'b0, b4.o_Paused}, {1'b0, e.pau});
            chk("enable", idx, {1'b0, b4.o_Enable}, {1'b0, ~e.pau});
        end
    endtask

    initial begin
        logic [1:0] bseq [8];
        b4.i_Switch_1 = 1'b1; b4.i_Switch_2 = 1'b0; b4.i_Toggle = 1'b0;
        b1.i_Switch_1 = 1'b1; b1.i_Switch_2 = 1'b0; b1.i_Toggle = 1'b0;
        // reset with switch 1 held high: no mode change on release
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // manual stepping; toggle edges in between are ignored
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 1, 0, 2'(i + 1), 0, 0);
            add(0, 0, 0, 1, 2'(i + 1), 0, 0);
        end
        // reset with toggle held high, then enter SCAN
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 0, (k % 2 == 1) ? 1'b0 : 1'b1, 2'(k / 4), 1, 0);
        // pause after 2 dwell edges, 3 ignored edges, resume, 2 more edges advance
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        // paused, then switch 1 + switch 2 + toggle edge together: mode change wins
        add(0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 1, 1);
        add(0, 1, 1, 1, 1, M2, 0);
        add(0, 0, 0, 1, 1, M2, 0);
        // reset mid-dwell while paused
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        foreach (tbl[i]) apply(tbl[i], i);
        // bounce sequence on the DWELL_EDGES=1 instance
`ifdef LED_SCHED_BOUNCE_EN
        bseq = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
`else
        bseq = '{default: 2'd0};
`endif
        tbl.delete();
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, M2, 0, 1);
        add(0, 0, 0, 0, 0, M2, 0, 1);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 1'(k % 2), bseq[k - 1], M2, 0, 1);
        foreach (tbl[i]) apply(tbl[i], 1000 + i);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
